fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of a sync_fifo instance among N requesters.
- Round-robin arbitration with a bounded burst lock.
- Each accepted beat is written as {source_id, data}, so the read side can demultiplex.
- Sits between peripheral producers (e.g. UART/SPI RX paths) and a shared sync_fifo; drives that FIFO's wr_en/wr_data and observes its full.

Parameters:
- N, 4, number of requesters (2 to 8).
- W, 8, data width per requester.
- IDW, 2, source-id width; must satisfy 2**IDW >= N.
- BURST, 4, maximum beats per grant (1 to 16).

Ports:
- clk  input  1  block clock, shared with the FIFO.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  N  per-requester beat valid.
- req_data  input  N*W  per-requester data; requester i uses bits [i*W +: W].
- req_last  input  N  marks the final beat of the requester's packet.
- req_ready  output  N  per-requester beat accept.
- fifo_full  input  1  full flag from the shared FIFO.
- fifo_wr_en  output  1  write strobe to the FIFO.
- fifo_wr_data  output  IDW+W  {grant_id, req_data[grant_id]}.
- grant_id  output  IDW  currently granted requester.
- busy  output  1  high while in GRANT.

Behaviour:
- Clock/reset (already decided): one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, grant_id=0, last_ptr=N-1, beat_cnt=0, req_ready=0, fifo_wr_en=0, busy=0.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any req_valid is high, select the first valid index searching last_ptr+1, last_ptr+2, … modulo N.
  - Register grant_id=sel and last_ptr=sel; beat_cnt=0; go to GRANT.
  - Arbitration costs exactly 1 cycle; no beat is accepted in IDLE.
- GRANT, with g=grant_id:
  - req_ready[g] = ~fifo_full, combinational; every other req_ready bit is 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - fifo_wr_data = {g, req_data[g]}.
  - A beat is accepted when fifo_wr_en=1; beat_cnt then increments by 1.
- Release GRANT → IDLE at the clock edge after any of:
  - a beat is accepted with req_last[g]=1;
  - a beat is accepted with beat_cnt==BURST-1;
  - req_valid[g]=0 in a GRANT cycle (a gap releases the grant and prevents hogging).
- On release:
  - beat_cnt clears.
  - A requester cut off by BURST competes again in the next IDLE.
  - Because last_ptr=g, the other requesters are searched first.
- fifo_full=1 in GRANT:
  - No write and no ready; grant is held.
  - beat_cnt does not advance.
  - Holding a stalled grant does not count as a gap as long as req_valid[g] stays high.
- FIFO overflow is impossible by construction: fifo_wr_en is never asserted while fifo_full=1.
- Non-granted requesters must hold valid/data stable; the block never drops a presented beat.
- Throughput:
  - Peak 1 beat/cycle within a grant.
  - Each grant costs 1 idle arbitration cycle; a BURST=4 burst occupies 5 cycles.
- Wrap-around:
  - last_ptr wraps from N-1 to 0.
  - beat_cnt is $clog2(BURST)+1 bits wide and never exceeds BURST-1.
- Reset asserted mid-GRANT:
  - Next edge returns all state to reset values.
  - A beat being presented in that cycle is not written.
- req_valid from an out-of-range index (≥N) does not exist; unused id codes are never emitted.

Optional Feature:
- Macro: FIFO_WR_ARB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[15:0], counting cycles in GRANT with req_valid[g]=1 and fifo_full=1.
  - The counter saturates at 16'hFFFF.
  - It is cleared by reset, or by new input stall_clr (1 bit, synchronous, takes priority over increment).
- When undefined: neither port exists and there is no counter logic; all other behaviour is identical.

Test Plan:
- Single requester, N=4, BURST=4:
  - req 2 sends 3 beats 0xA1,0xA2,0xA3 with last on 0xA3, fifo never full.
  - Expect grant_id=2 one cycle after valid.
  - Expect fifo_wr_data 0x2A1,0x2A2,0x2A3 on consecutive cycles, then IDLE.
- All four requesters stream continuously, no last:
  - Expect grants in order 0,1,2,3,0.
  - Each grant writes exactly 4 beats; one idle cycle between grants.
- Backpressure:
  - req 1 granted, fifo_full held high 5 cycles mid-burst after beat 2.
  - Expect fifo_wr_en=0 and req_ready=0 for those 5 cycles, grant held.
  - Beats 3–4 are written after full drops; total 4 beats.
- Gap release:
  - req 0 drops valid after 1 beat while req 3 is valid.
  - Expect release next edge, then grant_id=3.
  - req 0 is re-granted only after req 3.
- Reset mid-GRANT:
  - Assert reset during beat 2 of a burst.
  - Expect busy=0, req_ready=0, fifo_wr_en=0 next cycle; first post-reset grant goes to the lowest valid index ≥0.
- Stall counter (macro defined): 20 full cycles while granted and valid → stall_cnt=20; stall_clr pulse → 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//
// Bundles the request-side handshake and the shared-FIFO write port that the
// fifo_wr_arbiter sits between.
//
// Parameters:
//   N   - number of requesters
//   W   - data width per requester
//   IDW - source-id width
//
// Signals:
//   req_valid[N]      per-requester beat valid
//   req_data[N*W]     per-requester data, requester i on [i*W +: W]
//   req_last[N]       final beat of the requester's packet
//   req_ready[N]      per-requester beat accept
//   fifo_full         full flag from the shared FIFO
//   fifo_wr_en        write strobe to the FIFO
//   fifo_wr_data      {grant_id, data of the granted requester}
//   grant_id          currently granted requester
//   busy              high while a grant is held
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding environment (producers plus the FIFO)
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int IDW = 2
);
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ready;
   logic             fifo_full;
   logic             fifo_wr_en;
   logic [IDW+W-1:0] fifo_wr_data;
   logic [IDW-1:0]   grant_id;
   logic             busy;

   modport slave (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
   );

   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of a sync_fifo among N requesters using
// round-robin arbitration with a bounded burst lock. Every accepted beat is
// written as {source_id, data} so the read side can demultiplex.
//
// Parameters:
//   N     - number of requesters (2..8)
//   W     - data width per requester
//   IDW   - source-id width, 2**IDW >= N
//   BURST - maximum beats per grant (1..16)
//
// Ports:
//   clk        block clock, shared with the FIFO
//   reset      synchronous, active-high reset
//   bus        fifo_wr_arbiter_if.slave (requests, FIFO write port, status)
//   stall_clr  (optional) synchronous clear of stall_cnt
//   stall_cnt  (optional) saturating count of stalled grant cycles
//
// Optional feature macro: FIFO_WR_ARB_STALL_CNT_EN
//   When defined, adds stall_clr/stall_cnt. stall_cnt counts cycles in GRANT
//   with the granted requester valid and the FIFO full, saturating at 16'hFFFF.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int IDW   = 2,
   parameter int BURST = 4
) (
   input  logic        clk,
   input  logic        reset,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   input  logic        stall_clr,
   output logic [15:0] stall_cnt,
`endif
   fifo_wr_arbiter_if.slave bus
);

   localparam int NP = 2 ** IDW;
   localparam int CW = $clog2(BURST) + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state;
   logic [IDW-1:0] gid_q;
   logic [IDW-1:0] last_ptr;
   logic [CW-1:0]  beat_cnt;

   logic [NP-1:0]  valid_pad;
   logic [NP-1:0]  last_pad;
   logic [NP-1:0]  ready_pad;
   logic [W-1:0]   data_arr [NP];
   logic [IDW-1:0] sel;
   logic [IDW-1:0] cand;
   logic           any_valid;
   logic           in_grant;
   logic           cur_valid;
   logic           cur_last;
   logic           accept;

   // Widen the request vectors to the full id space so grant_id can index
   // them directly; ids >= N read as idle requesters and are never selected.
   always_comb begin
      valid_pad = NP'(bus.req_valid);
      last_pad  = NP'(bus.req_last);
      for (int i = 0; i < NP; i++) data_arr[i] = '0;
      for (int i = 0; i < N; i++) data_arr[i] = bus.req_data[i*W +: W];
   end

   // Round-robin search starting just after the last granted index. Walking
   // the offsets from farthest to nearest lets the nearest valid one win.
   always_comb begin
      sel       = last_ptr;
      cand      = '0;
      any_valid = 1'b0;
      for (int k = N; k >= 1; k--) begin
         cand = IDW'((int'(last_ptr) + k) % N);
         if (valid_pad[cand]) begin
            sel       = cand;
            any_valid = 1'b1;
         end
      end
   end

   // Write path is combinational from the held grant. Reset gates it so a
   // beat presented in the reset cycle is neither accepted nor written.
   always_comb begin
      in_grant  = (state == GRANT) && !reset;
      cur_valid = valid_pad[gid_q];
      cur_last  = last_pad[gid_q];
      accept    = in_grant && cur_valid && !bus.fifo_full;
      ready_pad = '0;
      if (in_grant) ready_pad[gid_q] = !bus.fifo_full;
   end

   assign bus.req_ready    = ready_pad[N-1:0];
   assign bus.fifo_wr_en   = accept;
   assign bus.fifo_wr_data = {gid_q, data_arr[gid_q]};
   assign bus.grant_id     = gid_q;
   assign bus.busy         = (state == GRANT);

   // Two-state arbiter. IDLE spends exactly one cycle picking the next owner;
   // GRANT streams beats until last, burst limit, or a valid gap. A full FIFO
   // only pauses the grant: nothing is written and the beat count holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         gid_q    <= '0;
         last_ptr <= IDW'(N - 1);
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  gid_q    <= sel;
                  last_ptr <= sel;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (!cur_valid) begin
                  beat_cnt <= '0;
                  state    <= IDLE;
               end else if (accept) begin
                  if (cur_last || (beat_cnt == CW'(BURST - 1))) begin
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + CW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
   // Counts cycles where the owner has a beat ready but the FIFO refuses it.
   // Clear wins over increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (reset || stall_clr) begin
         stall_cnt <= '0;
      end else if ((state == GRANT) && cur_valid && bus.fifo_full &&
                   (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
